// File: rtl/monitor_ctrl.sv
// Monitor control/UART register window: STATUS/RXDATA/TXDATA/RXCOUNT/CONTROL, RX FIFO, TX holding
// byte, break/step control and monitor IRQ. Optional loopback via MONITOR_CTRL_LOOPBACK_EN.
module monitor_ctrl #(
    parameter int unsigned RX_DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_cpu_address,
    input  logic [7:0] i_cpu_di,
    input  logic       i_ctrl_write,
    input  logic       i_ctrl_read,
    output logic [7:0] o_ctrl,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_strobe,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_monitor_irq,
    output logic       o_break_req,
    output logic       o_cpu_step
);

    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0]   RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_DEPTH_LOG2:0]   CNT_ONE = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LOG2-1:0] PTR_ONE = {{(RX_DEPTH_LOG2-1){1'b0}}, 1'b1};

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_RXDATA  = 4'd1;
    localparam logic [3:0] ADDR_TXDATA  = 4'd2;
    localparam logic [3:0] ADDR_RXCOUNT = 4'd3;
    localparam logic [3:0] ADDR_CONTROL = 4'd4;

    logic [7:0]               r_ctrl;
    logic                     r_prev_read;
    logic [3:0]               r_prev_addr;
    logic [7:0]               r_tx_data;
    logic                     r_tx_valid;
    logic                     r_tx_overrun;
    logic                     r_rx_overflow;
    logic                     r_rx_irq_en;
    logic                     r_break_req;
    logic                     r_cpu_step;
    logic                     r_monitor_irq;
    logic [7:0]               r_rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] r_rx_wr_ptr;
    logic [RX_DEPTH_LOG2-1:0] r_rx_rd_ptr;
    logic [RX_DEPTH_LOG2:0]   r_rx_count;

    logic       w_rd_fire;
    logic       w_status_wr;
    logic       w_tx_wr;
    logic       w_control_wr;
    logic       w_tx_load_req;
    logic       w_tx_load;
    logic       w_tx_drop;
    logic       w_push_req;
    logic [7:0] w_push_data;
    logic       w_push;
    logic       w_pop;
    logic       w_overflow_set;
    logic       w_rx_nonempty;
    logic       w_rx_full;
    logic [7:0] w_rx_head;
    logic       w_ctrl_b3;
    logic [7:0] w_rd_data;

    // A read held over several cycles at one address is a single access.
    assign w_rd_fire = i_ctrl_read & ~(r_prev_read & (r_prev_addr == i_cpu_address));

    assign w_status_wr  = i_ctrl_write & (i_cpu_address == ADDR_STATUS);
    assign w_tx_wr      = i_ctrl_write & (i_cpu_address == ADDR_TXDATA);
    assign w_control_wr = i_ctrl_write & (i_cpu_address == ADDR_CONTROL);

    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_rx_full     = (r_rx_count == RX_FULL);
    assign w_rx_head     = r_rx_mem[r_rx_rd_ptr];

`ifdef MONITOR_CTRL_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_loopback <= 1'b0;
        end else if (w_control_wr) begin
            r_loopback <= i_cpu_di[3];
        end
    end

    // In loopback, TXDATA writes feed the RX FIFO and the UART receiver is ignored.
    assign w_push_req    = r_loopback ? w_tx_wr : i_rx_strobe;
    assign w_push_data   = r_loopback ? i_cpu_di : i_rx_data;
    assign w_tx_load_req = w_tx_wr & ~r_loopback;
    assign w_ctrl_b3     = r_loopback;
`else
    assign w_push_req    = i_rx_strobe;
    assign w_push_data   = i_rx_data;
    assign w_tx_load_req = w_tx_wr;
    assign w_ctrl_b3     = 1'b0;
`endif

    assign w_tx_load = w_tx_load_req & (~r_tx_valid | i_tx_ready);
    assign w_tx_drop = w_tx_load_req & r_tx_valid & ~i_tx_ready;

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is not an overflow.
    assign w_pop          = w_rd_fire & (i_cpu_address == ADDR_RXDATA) & w_rx_nonempty;
    assign w_push         = w_push_req & (~w_rx_full | w_pop);
    assign w_overflow_set = w_push_req & w_rx_full & ~w_pop;

    always_comb begin
        w_rd_data = 8'h00;
        case (i_cpu_address)
            ADDR_STATUS: begin
                w_rd_data = {3'b000, r_monitor_irq, r_tx_overrun, r_rx_overflow,
                             ~r_tx_valid, w_rx_nonempty};
            end
            ADDR_RXDATA: begin
                w_rd_data = w_rx_nonempty ? w_rx_head : 8'h00;
            end
            ADDR_RXCOUNT: begin
                w_rd_data = {{(7 - RX_DEPTH_LOG2){1'b0}}, r_rx_count};
            end
            ADDR_CONTROL: begin
                w_rd_data = {4'b0000, w_ctrl_b3, 1'b0, r_break_req, r_rx_irq_en};
            end
            default: begin
                w_rd_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl      <= 8'h00;
            r_prev_read <= 1'b0;
            r_prev_addr <= 4'h0;
        end else begin
            r_prev_read <= i_ctrl_read;
            r_prev_addr <= i_cpu_address;
            if (w_rd_fire) begin
                r_ctrl <= w_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_tx_overrun <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_tx_data  <= i_cpu_di;
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid & i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            // Set wins over a simultaneous write-1-clear.
            r_tx_overrun <= w_tx_drop | (r_tx_overrun & ~(w_status_wr & i_cpu_di[3]));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_irq_en <= 1'b0;
            r_break_req <= 1'b0;
            r_cpu_step  <= 1'b0;
        end else begin
            if (w_control_wr) begin
                r_rx_irq_en <= i_cpu_di[0];
                r_break_req <= i_cpu_di[1];
            end
            r_cpu_step <= w_control_wr & i_cpu_di[2];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_overflow <= 1'b0;
            r_monitor_irq <= 1'b0;
        end else begin
            r_rx_overflow <= w_overflow_set | (r_rx_overflow & ~(w_status_wr & i_cpu_di[2]));
            r_monitor_irq <= (r_rx_irq_en & w_rx_nonempty) | r_rx_overflow;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(RX_DEPTH); i++) begin
                r_rx_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_rx_mem[r_rx_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    assign o_ctrl        = r_ctrl;
    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_monitor_irq = r_monitor_irq;
    assign o_break_req   = r_break_req;
    assign o_cpu_step    = r_cpu_step;

endmodule

// File: tb/tb_monitor_ctrl.sv
// Directed self-checking bench for monitor_ctrl (default build, loopback disabled).
module tb_monitor_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] cpu_address;
    logic [7:0] cpu_di;
    logic       ctrl_write;
    logic       ctrl_read;
    logic [7:0] ctrl;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       monitor_irq;
    logic       break_req;
    logic       cpu_step;

    int errors = 0;
    int checks = 0;
    logic [7:0] rd;

    monitor_ctrl #(.RX_DEPTH_LOG2(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cpu_address (cpu_address),
        .i_cpu_di      (cpu_di),
        .i_ctrl_write  (ctrl_write),
        .i_ctrl_read   (ctrl_read),
        .o_ctrl        (ctrl),
        .i_rx_data     (rx_data),
        .i_rx_strobe   (rx_strobe),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready),
        .o_monitor_irq (monitor_irq),
        .o_break_req   (break_req),
        .o_cpu_step    (cpu_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One read access followed by an idle cycle so back-to-back reads are distinct accesses.
    task automatic reg_rd(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk);
        cpu_address = addr;
        ctrl_read   = 1'b1;
        @(posedge clk);
        #1;
        ctrl_read = 1'b0;
        data      = ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_address = addr;
        cpu_di      = data;
        ctrl_write  = 1'b1;
        @(posedge clk);
        #1;
        ctrl_write = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] data);
        @(negedge clk);
        rx_data   = data;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cpu_address = 4'h0;
        cpu_di      = 8'h00;
        ctrl_write  = 1'b0;
        ctrl_read   = 1'b0;
        rx_data     = 8'h00;
        rx_strobe   = 1'b0;
        tx_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", ctrl, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_irq", {7'b0, monitor_irq}, 8'h00);
        chk("rst_break", {7'b0, break_req}, 8'h00);
        chk("rst_step", {7'b0, cpu_step}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        reg_rd(4'd0, rd); chk("status_after_reset", rd, 8'h02);
        reg_rd(4'd3, rd); chk("rxcount_after_reset", rd, 8'h00);

        rx_push(8'h41);
        rx_push(8'h42);
        reg_rd(4'd0, rd); chk("status_rx_nonempty", rd, 8'h03);
        reg_rd(4'd1, rd); chk("rxdata_first", rd, 8'h41);
        reg_rd(4'd1, rd); chk("rxdata_second", rd, 8'h42);
        reg_rd(4'd3, rd); chk("rxcount_drained", rd, 8'h00);
        reg_rd(4'd1, rd); chk("rxdata_empty", rd, 8'h00);
        reg_rd(4'd0, rd); chk("status_empty_read_no_flag", rd, 8'h02);

        // Held read: one access, one pop.
        rx_push(8'h10);
        rx_push(8'h20);
        @(negedge clk);
        cpu_address = 4'd1;
        ctrl_read   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ctrl_read = 1'b0;
        chk("held_read_data", ctrl, 8'h10);
        @(posedge clk);
        #1;
        reg_rd(4'd3, rd); chk("held_read_count", rd, 8'h01);
        reg_rd(4'd1, rd); chk("held_read_remaining", rd, 8'h20);

        // Fill past capacity: 0x00..0x0F stored, 0x10 dropped.
        for (int i = 0; i < 17; i++) begin
            rx_push(8'(i));
        end
        reg_rd(4'd3, rd); chk("rxcount_full", rd, 8'h10);
        reg_rd(4'd0, rd); chk("status_overflow", rd, 8'h17);
        chk("irq_overflow", {7'b0, monitor_irq}, 8'h01);

        // Push and pop together while full.
        @(negedge clk);
        cpu_address = 4'd1;
        ctrl_read   = 1'b1;
        rx_data     = 8'hAA;
        rx_strobe   = 1'b1;
        @(posedge clk);
        #1;
        ctrl_read = 1'b0;
        rx_strobe = 1'b0;
        chk("pushpop_head", ctrl, 8'h00);
        @(posedge clk);
        #1;
        reg_rd(4'd3, rd); chk("pushpop_count", rd, 8'h10);
        reg_rd(4'd0, rd); chk("pushpop_overflow_kept", rd, 8'h17);
        reg_wr(4'd0, 8'h04);
        // irq register still reflects the overflow seen before the clear.
        reg_rd(4'd0, rd); chk("status_w1c_overflow", rd, 8'h13);
        chk("irq_after_clear", {7'b0, monitor_irq}, 8'h00);
        for (int i = 1; i < 16; i++) begin
            reg_rd(4'd1, rd); chk("drain", rd, 8'(i));
        end
        reg_rd(4'd1, rd); chk("drain_last", rd, 8'hAA);
        reg_rd(4'd3, rd); chk("drain_count", rd, 8'h00);

        // TX overrun and handshake.
        reg_wr(4'd2, 8'h55);
        chk("tx_load_valid", {7'b0, tx_valid}, 8'h01);
        chk("tx_load_data", tx_data, 8'h55);
        reg_wr(4'd2, 8'h66);
        chk("tx_overrun_data_kept", tx_data, 8'h55);
        reg_rd(4'd0, rd); chk("status_tx_overrun", rd, 8'h08);
        reg_rd(4'd2, rd); chk("txdata_reads_zero", rd, 8'h00);
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("tx_valid_cleared", {7'b0, tx_valid}, 8'h00);
        @(negedge clk);
        tx_ready = 1'b0;
        reg_wr(4'd0, 8'h08);
        reg_rd(4'd0, rd); chk("status_w1c_overrun", rd, 8'h02);

        // Break and single step.
        reg_wr(4'd4, 8'h06);
        chk("break_set", {7'b0, break_req}, 8'h01);
        chk("step_pulse", {7'b0, cpu_step}, 8'h01);
        @(posedge clk);
        #1;
        chk("step_one_cycle", {7'b0, cpu_step}, 8'h00);
        reg_rd(4'd4, rd); chk("control_readback", rd, 8'h02);

        // RX interrupt enable.
        reg_wr(4'd4, 8'h01);
        chk("break_cleared", {7'b0, break_req}, 8'h00);
        rx_push(8'h77);
        chk("irq_latency", {7'b0, monitor_irq}, 8'h00);
        @(posedge clk);
        #1;
        chk("irq_rx_enabled", {7'b0, monitor_irq}, 8'h01);
        reg_rd(4'd1, rd); chk("rxdata_irq_byte", rd, 8'h77);
        chk("irq_rx_drained", {7'b0, monitor_irq}, 8'h00);
        reg_rd(4'd7, rd); chk("unmapped_read", rd, 8'h00);

        // Reset mid-transfer discards TX and RX.
        reg_wr(4'd2, 8'h99);
        chk("tx_pending", {7'b0, tx_valid}, 8'h01);
        rx_push(8'h12);
        reg_rd(4'd4, rd); chk("control_before_reset", rd, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("midreset_tx_data", tx_data, 8'h00);
        chk("midreset_ctrl", ctrl, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        reg_rd(4'd3, rd); chk("midreset_rxcount", rd, 8'h00);
        reg_rd(4'd4, rd); chk("midreset_control", rd, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
